// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed scan driver for a common-anode seven-segment
// display. Holds a frame of BCD digits, steps through them every SCAN_DIV
// cycles and swaps in newly loaded frames only at the frame boundary.
//
// Optional feature: define SSD_LZ_BLANK_EN to blank leading zeros (the anode
// of a blanked digit stays high during its slot; digit 0 is never blanked).
//
// Ports:
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset
//   load       in  one-cycle strobe capturing digits_in / dp_in
//   digits_in  in  BCD frame, nibble k = digit k (digit 0 rightmost)
//   dp_in      in  decimal point per digit
//   bcd        out BCD code of the selected digit (to bcd_ssd decoder)
//   dp         out decimal point of the selected digit, active-high
//   an         out anode enables, active-low, at most one low
//   loaded     out one-cycle pulse when a pending frame goes on display
//   pending    out a captured frame is waiting for the frame boundary
module ssd_scan_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [3:0]                bcd,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      loaded,
    output logic                      pending
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         disp;
    logic [DW-1:0]         pend;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] blank;
    logic                  tick;
    logic                  wrap;

    assign tick = (pcnt == PW'(SCAN_DIV - 1));
    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    // Prescaler, digit index and frame double-buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt    <= '0;
            idx     <= '0;
            disp    <= '0;
            disp_dp <= '0;
            pend    <= '0;
            pend_dp <= '0;
            pending <= 1'b0;
            loaded  <= 1'b0;
        end else begin
            loaded <= 1'b0;

            if (tick) begin
                pcnt <= '0;
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                pcnt <= pcnt + PW'(1);
            end

            if (wrap && load) begin
                // Load on the boundary goes straight to the display; any
                // older pending frame is superseded.
                disp    <= digits_in;
                disp_dp <= dp_in;
                pending <= 1'b0;
                loaded  <= 1'b1;
            end else if (wrap && pending) begin
                disp    <= pend;
                disp_dp <= pend_dp;
                pending <= 1'b0;
                loaded  <= 1'b1;
            end else if (load) begin
                pend    <= digits_in;
                pend_dp <= dp_in;
                pending <= 1'b1;
            end
        end
    end

`ifdef SSD_LZ_BLANK_EN
    // Digit k blanks when it and every more-significant digit are zero and
    // its own decimal point is off.
    always_comb begin
        logic upper_zero;
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (disp[4*k +: 4] == 4'd0);
            blank[k]   = upper_zero & ~disp_dp[k];
        end
    end
`else
    assign blank = '0;
`endif

    // Output decode of the selected digit.
    always_comb begin
        bcd = 4'd0;
        dp  = 1'b0;
        an  = '1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx == IW'(k)) begin
                bcd   = disp[4*k +: 4];
                dp    = disp_dp[k];
                an[k] = blank[k];
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Testbench for ssd_scan_mux (NUM_DIGITS=4, SCAN_DIV=4). A driver issues one
// cycle of stimulus at a time, advances a frame-level reference model and
// queues the outputs expected after the next clock edge; a monitor pops and
// compares after every rising edge.
module tb_ssd_scan_mux;

    localparam int unsigned N = 4;
    localparam int unsigned S = 4;
    localparam int unsigned F = N * S;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dp;
        logic       loaded;
        logic       pending;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    bcd;
    logic          dp;
    logic [3:0]    an;
    logic          loaded;
    logic          pending;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    bit            done = 1'b0;

    // Reference model state: cycles since reset plus frame contents.
    int unsigned   t = 0;
    logic [15:0]   m_disp = '0;
    logic [3:0]    m_disp_dp = '0;
    logic [15:0]   m_pend = '0;
    logic [3:0]    m_pend_dp = '0;
    logic          m_pending = 1'b0;
    logic          m_loaded = 1'b0;

    ssd_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .bcd       (bcd),
        .dp        (dp),
        .an        (an),
        .loaded    (loaded),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_outputs();
        exp_t        e;
        int unsigned slot;
        logic [3:0]  one;
        logic        blanked;
        slot    = (t / S) % N;
        one     = 4'b0001;
        blanked = 1'b0;
`ifdef SSD_LZ_BLANK_EN
        if (slot >= 1 && (m_disp >> (4 * slot)) == 16'h0 && !m_disp_dp[slot])
            blanked = 1'b1;
`endif
        e.an      = blanked ? 4'hF : ~(one << slot);
        e.bcd     = 4'((m_disp >> (4 * slot)) & 16'hF);
        e.dp      = m_disp_dp[slot];
        e.loaded  = m_loaded;
        e.pending = m_pending;
        return e;
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, queue
    // the expected outputs, then wait for the falling edge.
    task automatic step(input logic r, input logic l, input logic [15:0] d,
                        input logic [3:0] p);
        logic w;
        rst       = r;
        load      = l;
        digits_in = d;
        dp_in     = p;
        if (r) begin
            t = 0; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0;
            m_pending = 1'b0; m_loaded = 1'b0;
        end else begin
            w        = (t % F == F - 1);
            m_loaded = 1'b0;
            if (w && l) begin
                m_disp = d; m_disp_dp = p; m_pending = 1'b0; m_loaded = 1'b1;
            end else if (w && m_pending) begin
                m_disp = m_pend; m_disp_dp = m_pend_dp; m_pending = 1'b0; m_loaded = 1'b1;
            end else if (l) begin
                m_pend = d; m_pend_dp = p; m_pending = 1'b1;
            end
            t++;
        end
        q.push_back(model_outputs());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("an",      int'(an),      int'(e.an));
                chk("bcd",     int'(bcd),     int'(e.bcd));
                chk("dp",      int'(dp),      int'(e.dp));
                chk("loaded",  int'(loaded),  int'(e.loaded));
                chk("pending", int'(pending), int'(e.pending));
            end else if (!done) begin
                chk("queue_underflow", 1, 0);
            end
        end
    end

    initial begin
        // Reset held two cycles with load asserted: nothing captured.
        step(1'b1, 1'b1, 16'hFFFF, 4'hF);
        step(1'b1, 1'b1, 16'hFFFF, 4'hF);
        idle(20);

        // Mid-frame load while idx=1.
        while (((t / S) % N) != 1) idle(1);
        step(1'b0, 1'b1, 16'h1234, 4'b0010);
        idle(2 * F);

        // Overwrite within one frame: latest wins, single loaded pulse.
        while ((t % F) != 2) idle(1);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        idle(3);
        step(1'b0, 1'b1, 16'h5678, 4'h0);
        idle(F + 4);

        // Load on the wrap cycle bypasses the pending stage.
        while ((t % F) != F - 1) idle(1);
        step(1'b0, 1'b1, 16'h9999, 4'h0);
        idle(6);

        // Reset while a frame is pending drops it.
        step(1'b0, 1'b1, 16'h4242, 4'h1);
        idle(2);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(F + 4);

        // Leading-zero patterns.
        step(1'b0, 1'b1, 16'h0045, 4'h0);
        idle(2 * F);
        step(1'b0, 1'b1, 16'h0000, 4'h0);
        idle(2 * F);
        step(1'b0, 1'b1, 16'h0005, 4'b1000);
        idle(2 * F);
        step(1'b0, 1'b1, 16'h0100, 4'h0);
        idle(2 * F);

        // Randomised traffic, occasional resets and zero-heavy frames.
        for (int i = 0; i < 3000; i++) begin
            logic        r, l;
            logic [15:0] d;
            logic [3:0]  p;
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 9) == 0);
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
            if ($urandom_range(0, 4) == 0) d = 16'h0;
            p = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(r, l, d, p);
        end
        idle(2);

        done = 1'b1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssd_scan_mux.md
# ssd_scan_mux

Time-multiplexed scan driver for a multi-digit common-anode seven-segment display. It holds a frame of BCD digits and steps through them at a prescaled rate. For each step it presents one digit's BCD code to the downstream `bcd_ssd` decoder and drives the matching active-low anode. New digit frames are accepted with a one-cycle load strobe and applied only at a frame boundary, so a frame is never partly old and partly new.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned (≥2).
- `SCAN_DIV`, default 100000: clock cycles each digit stays selected (≥1).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load`  in  1: one-cycle strobe; captures `digits_in` and `dp_in`.
- `digits_in`  in  4*NUM_DIGITS: BCD frame; nibble k is digit k; digit 0 is least significant and rightmost.
- `dp_in`  in  NUM_DIGITS: decimal-point bit per digit.
- `bcd`  out  4: BCD code of the selected digit; feeds `bcd_ssd.bcd`.
- `dp`  out  1: decimal point of the selected digit, active-high.
- `an`  out  NUM_DIGITS: anode enables, active-low, at most one low.
- `loaded`  out  1: one-cycle pulse when a pending frame becomes the displayed frame.
- `pending`  out  1: a captured frame is waiting for the frame boundary.

## Operation
- Registers:
  - prescaler `pcnt` (0..SCAN_DIV-1)
  - digit index `idx` (0..NUM_DIGITS-1)
  - display frame `disp`/`disp_dp`
  - pending frame `pend`/`pend_dp` plus `pending` flag
  - `loaded` flag
- `tick` = (`pcnt` == SCAN_DIV-1). On tick, `pcnt` goes to 0; otherwise `pcnt` increments.
- On tick, `idx` increments and wraps NUM_DIGITS-1 → 0. `wrap` = tick && `idx` == NUM_DIGITS-1.
- `load` without `wrap`: `pend` ← inputs and `pending` ← 1. A load while `pending` is already set overwrites `pend`; the latest frame wins.
- `wrap` with `pending` set and no `load`: `disp` ← `pend`, `pending` ← 0, `loaded` ← 1.
- `wrap` and `load` in the same cycle: `disp` ← `digits_in`/`dp_in` directly (bypass), `pending` ← 0, `loaded` ← 1. Any older pending frame is discarded.
- `loaded` is 0 in every other cycle.
- `bcd`, `dp` and `an` are combinational decodes of the registered `idx` and `disp`: `bcd` = `disp[idx]`, `an` = ~(1 << `idx`).
- BCD values 10–15 are passed through unchanged; validity belongs to the producer.

## Timing
- Reset (synchronous, priority over all other inputs):
  - `pcnt`=0, `idx`=0, `disp`=0, `disp_dp`=0, `pend`=0, `pending`=0, `loaded`=0.
  - Outputs after the reset edge: `an`=~1 (4'b1110 for 4 digits), `bcd`=0, `dp`=0, `loaded`=0, `pending`=0.
- Each digit is selected for exactly SCAN_DIV cycles; a frame lasts NUM_DIGITS*SCAN_DIV cycles.
- SCAN_DIV=1: tick every cycle, `idx` advances every edge.
- `pending` rises on the edge that samples `load` (one-cycle latency).
- The new frame is visible on `bcd` from the `wrap` edge onward. `loaded` is high for the cycle that follows that edge.
- Maximum load-to-display latency is NUM_DIGITS*SCAN_DIV cycles; the bypass case has 1 cycle.
- Reset mid-frame drops the pending frame, and no `loaded` pulse is produced for it.

## Configuration
- `SSD_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digit k (k ≥ 1) is blanked when `disp` digit k and every more-significant digit are 0 and `disp_dp[k]`=0.
  - For a blanked digit, `an` stays all-ones during its slot. `idx` timing is unchanged.
  - Digit 0 is never blanked.
- `SSD_LZ_BLANK_EN` undefined: every digit's anode is driven in its slot, leading zeros included.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4.
- Reset: hold `rst` for 2 cycles with `load`=1 → `an`=1110, `bcd`=0, `dp`=0, `pending`=0, `loaded`=0; no capture occurs.
- Free scan: no load for 20 cycles after reset → `an` steps 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; `bcd`=0 throughout.
- Mid-frame load: `load` with `digits_in`=16'h1234, `dp_in`=4'b0010 while `idx`=1 →
  - `pending`=1 and `bcd` stays 0 until the wrap.
  - At the wrap, `loaded` pulses once and `pending`=0.
  - Next frame: `bcd` = 4, 3, 2, 1; `dp`=1 only in the `idx`=1 slot.
- Overwrite, bypass and reset:
  - Loads of 16'h1111 then 16'h5678 in the same frame → only 5678 is displayed, with one `loaded` pulse.
  - Load of 16'h9999 on the wrap cycle → `bcd`=9 on the next cycle and `pending` stays 0.
  - `rst` while `pending`=1 → `pending`=0 and the display stays 0.
- Leading-zero blanking:
  - With `SSD_LZ_BLANK_EN`, `digits_in`=16'h0045 → `an` is 1111 in slots 2 and 3.
  - With `SSD_LZ_BLANK_EN`, 16'h0000 → only slot 0 shows 1110.
  - Without the macro, both frames drive all four anodes in their slots.
